// File: rtl/memory_bus_pkg.sv
// Slave-side bus command/result types shared by the memory-mapped peripherals.
package MemoryBus;
   typedef struct packed {
      logic [31:0] write_data;
      logic [3:0]  mask_byte;
      logic        mem_read;
   } Cmd;

   typedef struct packed {
      logic [31:0] read_data;
   } Result;
endpackage

// File: rtl/uart_pkg.sv
// Register map, status/control bit positions and transmitter state type.
package uart_pkg;
   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_DIVISOR = 2'd2;
   localparam logic [1:0] REG_CTRL    = 2'd3;

   localparam int ST_FULL      = 0;
   localparam int ST_EMPTY     = 1;
   localparam int ST_BUSY      = 2;
   localparam int ST_OVF       = 3;
   localparam int ST_COUNT_LSB = 8;

   localparam int CTRL_TX_EN    = 0;
   localparam int CTRL_IRQ_EN   = 1;
   localparam int CTRL_FIFO_CLR = 2;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted when a pop happens on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clr,
   input  logic [WIDTH-1:0]         data_in,
   output logic [WIDTH-1:0]         data_out,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign full      = (r_count == (AW+1)'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign data_out  = r_mem[r_rd_ptr];
   assign w_pop_ok  = pop && !empty;
   assign w_push_ok = push && (!full || w_pop_ok);

   always_ff @(posedge clk) begin
      if (w_push_ok && !clr) r_mem[r_wr_ptr] <= data_in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end
endmodule

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: register file, TX FIFO, baud down-counter and frame FSM.
//   state | meaning
//   IDLE  | line high, waiting for tx_en and a queued byte
//   START | start bit (low) for one bit time
//   DATA  | DATA_BITS data bits, LSB first
//   STOP  | STOP_BITS stop bits (high); chains straight into START if more data
module uart_tx_periph
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH    = 16,
   parameter int DATA_BITS     = 8,
   parameter int STOP_BITS     = 1,
   parameter int DIV_WIDTH     = 16,
   parameter int RESET_DIVISOR = 434
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             write_enable,
   input  logic [1:0]       bus_address,
   input  MemoryBus::Cmd    membuscmd,
   output MemoryBus::Result membusres,
   output logic             tx_o,
   output logic             irq_o
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int BIT_W = 4;

   tx_state_t              r_state, w_state_nxt;
   logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
   logic [BIT_W-1:0]       r_bit_idx, w_bit_idx_nxt;
   logic [DIV_WIDTH-1:0]   r_baud_cnt, w_baud_cnt_nxt;
   logic [DIV_WIDTH-1:0]   r_frame_div, w_frame_div_nxt;
   logic [DIV_WIDTH-1:0]   r_divisor, w_eff_div;
   logic                   r_tx_en, r_irq_en, r_ovf, r_irq, r_tx;
   logic                   w_tx_nxt, w_pop, w_load, w_tick, w_can_start;
   logic                   w_wr_b0, w_push, w_clr, w_ovf_clr, w_ctrl_wr, w_div_wr;
   logic                   w_full, w_empty, w_busy;
   logic [CNT_W-1:0]       w_count;
   logic [DATA_BITS-1:0]   w_fifo_dout;
   logic [31:0]            w_rdata;
   logic                   w_unused;

   assign w_wr_b0   = write_enable && membuscmd.mask_byte[0];
   assign w_push    = w_wr_b0 && (bus_address == REG_TXDATA);
   assign w_clr     = w_wr_b0 && (bus_address == REG_CTRL) && membuscmd.write_data[CTRL_FIFO_CLR];
   assign w_ovf_clr = w_wr_b0 && (bus_address == REG_STATUS) && membuscmd.write_data[ST_OVF];
   assign w_ctrl_wr = w_wr_b0 && (bus_address == REG_CTRL);
   assign w_div_wr  = write_enable && (bus_address == REG_DIVISOR);
   assign w_unused  = ^{membuscmd.write_data, membuscmd.mask_byte};

   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (w_push),
      .pop      (w_pop),
      .clr      (w_clr),
      .data_in  (membuscmd.write_data[DATA_BITS-1:0]),
      .data_out (w_fifo_dout),
      .full     (w_full),
      .empty    (w_empty),
      .count    (w_count)
   );

   assign w_busy      = (r_state != IDLE);
   assign w_eff_div   = (r_divisor == '0) ? DIV_WIDTH'(1) : r_divisor;
   assign w_tick      = (r_baud_cnt == '0);
   assign w_can_start = r_tx_en && !w_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_divisor <= DIV_WIDTH'(RESET_DIVISOR);
         r_tx_en   <= 1'b1;
         r_irq_en  <= 1'b0;
         r_ovf     <= 1'b0;
         r_irq     <= 1'b0;
      end else begin
         for (int i = 0; i < DIV_WIDTH; i++) begin
            if (w_div_wr && membuscmd.mask_byte[i/8]) r_divisor[i] <= membuscmd.write_data[i];
         end
         if (w_ctrl_wr) begin
            r_tx_en  <= membuscmd.write_data[CTRL_TX_EN];
            r_irq_en <= membuscmd.write_data[CTRL_IRQ_EN];
         end
         // a byte lost to fifo_clr is not an overflow
         if (w_push && w_full && !w_pop && !w_clr) r_ovf <= 1'b1;
         else if (w_ovf_clr)                     r_ovf <= 1'b0;
         r_irq <= r_irq_en && w_empty && !w_busy;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_shift     <= '0;
         r_bit_idx   <= '0;
         r_baud_cnt  <= '0;
         r_frame_div <= DIV_WIDTH'(1);
         r_tx        <= 1'b1;
      end else begin
         r_state     <= w_state_nxt;
         r_shift     <= w_shift_nxt;
         r_bit_idx   <= w_bit_idx_nxt;
         r_baud_cnt  <= w_baud_cnt_nxt;
         r_frame_div <= w_frame_div_nxt;
         r_tx        <= w_tx_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_shift_nxt     = r_shift;
      w_bit_idx_nxt   = r_bit_idx;
      w_baud_cnt_nxt  = w_tick ? (r_frame_div - DIV_WIDTH'(1)) : (r_baud_cnt - DIV_WIDTH'(1));
      w_frame_div_nxt = r_frame_div;
      w_load          = 1'b0;
      w_pop           = 1'b0;
      case (r_state)
         IDLE: begin
            w_baud_cnt_nxt = r_baud_cnt;
            w_load         = w_can_start;
         end
         START: begin
            if (w_tick) begin
               w_state_nxt   = DATA;
               w_bit_idx_nxt = '0;
            end
         end
         DATA: begin
            if (w_tick) begin
               if (r_bit_idx == BIT_W'(DATA_BITS - 1)) begin
                  w_state_nxt   = STOP;
                  w_bit_idx_nxt = '0;
               end else begin
                  w_shift_nxt   = r_shift >> 1;
                  w_bit_idx_nxt = r_bit_idx + BIT_W'(1);
               end
            end
         end
         STOP: begin
            if (w_tick) begin
               if (r_bit_idx == BIT_W'(STOP_BITS - 1)) begin
                  w_state_nxt = IDLE;
                  w_load      = w_can_start;
               end else begin
                  w_bit_idx_nxt = r_bit_idx + BIT_W'(1);
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      // divisor is sampled once per frame so mid-frame writes wait for the next start
      if (w_load) begin
         w_pop           = 1'b1;
         w_shift_nxt     = w_fifo_dout;
         w_frame_div_nxt = w_eff_div;
         w_baud_cnt_nxt  = w_eff_div - DIV_WIDTH'(1);
         w_bit_idx_nxt   = '0;
         w_state_nxt     = START;
      end
      case (w_state_nxt)
         START:   w_tx_nxt = 1'b0;
         DATA:    w_tx_nxt = w_shift_nxt[0];
         default: w_tx_nxt = 1'b1;
      endcase
   end

   always_comb begin
      w_rdata = '0;
      case (bus_address)
         REG_STATUS: begin
            w_rdata[ST_FULL]                   = w_full;
            w_rdata[ST_EMPTY]                  = w_empty;
            w_rdata[ST_BUSY]                   = w_busy;
            w_rdata[ST_OVF]                    = r_ovf;
            w_rdata[ST_COUNT_LSB +: CNT_W]     = w_count;
         end
         REG_DIVISOR: w_rdata[DIV_WIDTH-1:0] = r_divisor;
         REG_CTRL: begin
            w_rdata[CTRL_TX_EN]  = r_tx_en;
            w_rdata[CTRL_IRQ_EN] = r_irq_en;
         end
         default: w_rdata = '0;
      endcase
   end

   assign membusres.read_data = membuscmd.mem_read ? w_rdata : 32'h0;
   assign tx_o  = r_tx;
   assign irq_o = r_irq;
endmodule

// File: tb/tb_uart_tx_periph.sv
// Scoreboard bench for uart_tx_periph: expected frames are queued at write time and checked on tx_o.
module tb_uart_tx_periph;
   import uart_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             write_enable = 1'b0;
   logic [1:0]       bus_address = 2'd0;
   MemoryBus::Cmd    membuscmd;
   MemoryBus::Result membusres;
   logic             tx_o;
   logic             irq_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int write_cyc = 0;

   typedef struct {
      logic [7:0] data;
      int         div;
   } frame_t;
   frame_t q_frame[$];

   uart_tx_periph dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .write_enable (write_enable),
      .bus_address  (bus_address),
      .membuscmd    (membuscmd),
      .membusres    (membusres),
      .tx_o         (tx_o),
      .irq_o        (irq_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
      @(negedge clk);
      bus_address          = a;
      membuscmd.write_data = d;
      membuscmd.mask_byte  = m;
      membuscmd.mem_read   = 1'b0;
      write_enable         = 1'b1;
      @(posedge clk);
      #1;
      write_cyc    = cyc;
      write_enable = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      bus_address        = a;
      membuscmd.mem_read = 1'b1;
      #1;
      d = membusres.read_data;
      membuscmd.mem_read = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] data, input int div, input bit accepted);
      frame_t f;
      f.data = data;
      f.div  = div;
      if (accepted) q_frame.push_back(f);
      bus_write(REG_TXDATA, {24'h0, data}, 4'hF);
   endtask

   task automatic rx_frame(output int start_cyc);
      frame_t     f;
      logic [9:0] bits;
      logic [7:0] got;
      int         t;
      int         bad;
      start_cyc = -1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (tx_o !== 1'b0 && t < 4000);
      checks++;
      if (tx_o !== 1'b0 || q_frame.size() == 0) begin
         errors++;
         $display("FAIL frame_start got tx_o=%b queued=%0d after %0d cycles, exp start bit with a queued frame",
                  tx_o, q_frame.size(), t);
         return;
      end
      f = q_frame.pop_front();
      start_cyc = cyc;
      bits = {1'b1, f.data, 1'b0};
      bad = 0;
      got = 8'h0;
      for (int b = 0; b < 10; b++) begin
         for (int k = 0; k < f.div; k++) begin
            if (b != 0 || k != 0) @(negedge clk);
            if (tx_o !== bits[b]) bad++;
            if (k == 0 && b >= 1 && b <= 8) got[b-1] = tx_o;
         end
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL frame_bits got=%h exp=%h div=%0d bad_samples=%0d", got, f.data, f.div, bad);
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (100) @(negedge clk);
      checks++;
      if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx_o); end
      checks++;
      if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
      bus_read(REG_STATUS, d);
      checks++;
      if (d !== 32'h2) begin errors++; $display("FAIL reset_status got=%h exp=%h", d, 32'h2); end
      bus_read(REG_DIVISOR, d);
      checks++;
      if (d !== 32'd434) begin errors++; $display("FAIL reset_divisor got=%0d exp=434", d); end
      bus_read(REG_CTRL, d);
      checks++;
      if (d !== 32'h1) begin errors++; $display("FAIL reset_ctrl got=%h exp=1", d); end
      bus_read(REG_TXDATA, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL txdata_read got=%h exp=0", d); end
   endtask

   task automatic test_mask();
      logic [31:0] d;
      bus_write(REG_DIVISOR, 32'h0000ABCD, 4'b0010);
      bus_read(REG_DIVISOR, d);
      checks++;
      if (d !== 32'hABB2) begin errors++; $display("FAIL divisor_bytemask got=%h exp=%h", d, 32'hABB2); end
      bus_write(REG_TXDATA, 32'h55, 4'b1110);
      repeat (3) @(negedge clk);
      bus_read(REG_STATUS, d);
      checks++;
      if (d !== 32'h2 || tx_o !== 1'b1) begin
         errors++;
         $display("FAIL txdata_mask got status=%h tx=%b exp status=2 tx=1", d, tx_o);
      end
      bus_write(REG_CTRL, 32'h2, 4'b0000);
      bus_read(REG_CTRL, d);
      checks++;
      if (d !== 32'h1) begin errors++; $display("FAIL ctrl_mask got=%h exp=1", d); end
   endtask

   task automatic test_frame();
      logic [31:0] d;
      int          s;
      bus_write(REG_DIVISOR, 32'd4, 4'hF);
      push_byte(8'hA5, 4, 1'b1);
      rx_frame(s);
      checks++;
      if (s != write_cyc + 1) begin errors++; $display("FAIL start_latency got=%0d exp=%0d", s, write_cyc + 1); end
      @(negedge clk);
      bus_read(REG_STATUS, d);
      checks++;
      if (d !== 32'h2) begin errors++; $display("FAIL idle_after_stop got=%h exp=2", d); end
   endtask

   task automatic test_overflow();
      logic [31:0] d;
      frame_t      f;
      bus_write(REG_DIVISOR, 32'd2, 4'hF);
      bus_write(REG_CTRL, 32'h0, 4'hF);
      for (int i = 0; i < 17; i++) push_byte(8'h10 + 8'(i), 2, i < 16);
      bus_read(REG_STATUS, d);
      checks++;
      if (d !== 32'h1009) begin errors++; $display("FAIL overflow_status got=%h exp=%h", d, 32'h1009); end
      bus_write(REG_STATUS, 32'h8, 4'hF);
      bus_read(REG_STATUS, d);
      checks++;
      if (d !== 32'h1001) begin errors++; $display("FAIL overflow_w1c got=%h exp=%h", d, 32'h1001); end
      f.data = 8'h5A;
      f.div  = 2;
      q_frame.push_back(f);
      fork
         begin
            int s;
            int prev;
            prev = 0;
            for (int i = 0; i < 17; i++) begin
               rx_frame(s);
               if (i > 0) begin
                  checks++;
                  if (s - prev != 20) begin
                     errors++;
                     $display("FAIL back_to_back_gap frame=%0d got=%0d exp=20", i, s - prev);
                  end
               end
               prev = s;
            end
         end
         begin
            logic [31:0] rd;
            bus_write(REG_CTRL, 32'h1, 4'hF);
            bus_write(REG_TXDATA, 32'h5A, 4'hF);
            bus_read(REG_STATUS, rd);
            checks++;
            if (rd !== 32'h1005) begin errors++; $display("FAIL push_on_pop_full got=%h exp=%h", rd, 32'h1005); end
         end
      join
      @(negedge clk);
      bus_read(REG_STATUS, d);
      checks++;
      if (d !== 32'h2 || q_frame.size() != 0) begin
         errors++;
         $display("FAIL drain_done got status=%h queued=%0d exp status=2 queued=0", d, q_frame.size());
      end
   endtask

   task automatic test_divisor_change();
      logic [31:0] d;
      frame_t      f;
      bus_write(REG_DIVISOR, 32'd3, 4'hF);
      f.data = 8'hC3; f.div = 3; q_frame.push_back(f);
      f.data = 8'h3C; f.div = 1; q_frame.push_back(f);
      fork
         begin
            int s1;
            int s2;
            rx_frame(s1);
            rx_frame(s2);
            checks++;
            if (s2 - s1 != 30) begin errors++; $display("FAIL divchg_frame1_len got=%0d exp=30", s2 - s1); end
         end
         begin
            bus_write(REG_TXDATA, 32'hC3, 4'hF);
            bus_write(REG_TXDATA, 32'h3C, 4'hF);
            repeat (10) @(negedge clk);
            bus_write(REG_DIVISOR, 32'd0, 4'hF);
         end
      join
      bus_read(REG_DIVISOR, d);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL divisor_zero_read got=%h exp=0", d); end
   endtask

   task automatic test_irq();
      logic [31:0] d;
      int          s;
      bus_write(REG_DIVISOR, 32'd2, 4'hF);
      bus_write(REG_CTRL, 32'h3, 4'hF);
      repeat (2) @(negedge clk);
      checks++;
      if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_idle got=%b exp=1", irq_o); end
      push_byte(8'h96, 2, 1'b1);
      fork
         rx_frame(s);
         begin
            repeat (6) @(negedge clk);
            checks++;
            if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_busy got=%b exp=0", irq_o); end
         end
      join
      checks++;
      if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_last_stop got=%b exp=0", irq_o); end
      @(negedge clk);
      bus_read(REG_STATUS, d);
      checks++;
      if (d !== 32'h2 || irq_o !== 1'b0) begin
         errors++;
         $display("FAIL irq_lag got status=%h irq=%b exp status=2 irq=0", d, irq_o);
      end
      @(negedge clk);
      checks++;
      if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_after_stop got=%b exp=1", irq_o); end
   endtask

   task automatic test_async_reset();
      logic [31:0] d;
      int          t;
      int          lows;
      bus_write(REG_CTRL, 32'h1, 4'hF);
      bus_write(REG_DIVISOR, 32'd4, 4'hF);
      for (int i = 0; i < 3; i++) bus_write(REG_TXDATA, 32'h00, 4'hF);
      t = 0;
      while (tx_o !== 1'b0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      repeat (9) @(negedge clk);
      checks++;
      if (tx_o !== 1'b0) begin errors++; $display("FAIL rst_pre_data got=%b exp=0", tx_o); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (tx_o !== 1'b1 || irq_o !== 1'b0) begin
         errors++;
         $display("FAIL rst_immediate got tx=%b irq=%b exp tx=1 irq=0", tx_o, irq_o);
      end
      q_frame.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      bus_read(REG_STATUS, d);
      checks++;
      if (d !== 32'h2) begin errors++; $display("FAIL rst_status got=%h exp=2", d); end
      bus_read(REG_DIVISOR, d);
      checks++;
      if (d !== 32'd434) begin errors++; $display("FAIL rst_divisor got=%0d exp=434", d); end
      lows = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (tx_o !== 1'b1) lows++;
      end
      checks++;
      if (lows != 0) begin errors++; $display("FAIL rst_no_frames got low_samples=%0d exp=0", lows); end
   endtask

   initial begin
      membuscmd = '0;
      test_reset();
      test_mask();
      test_frame();
      test_overflow();
      test_divisor_change();
      test_irq();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/uart_tx_periph.md
Name: uart_tx_periph

Overview:
- Memory-mapped UART transmitter slave; replaces the bit-banged TXD tap on the UART window of the slave bus mux.
- Sits on slave port 2 of SlaveBusMux (4-word window), driven by MemoryBus::Cmd/Result.
- Buffers CPU writes in a parametrised FIFO and serialises them at a programmable baud rate.
- Provides status, overflow and TX-empty interrupt.

Parameters:
- FIFO_DEPTH, 16, TX FIFO entries; power of two, >=2.
- DATA_BITS, 8, bits per frame, 5..8, LSB first.
- STOP_BITS, 1, stop bits per frame, 1 or 2.
- DIV_WIDTH, 16, width of the baud divisor register.
- RESET_DIVISOR, 434, divisor value at reset (50 MHz / 115200).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- write_enable  in  1  bus write strobe from the slave mux.
- bus_address  in  2  word offset within the window.
- membuscmd  in  MemoryBus::Cmd  write_data, mask_byte, mem_read.
- membusres  out  MemoryBus::Result  read data to the CPU.
- tx_o  out  1  serial output; idle high.
- irq_o  out  1  level interrupt: FIFO empty and not busy, gated by CTRL.irq_en.

Behaviour:
- Register map (word offset):
  - 0 TXDATA: WO push of write_data[DATA_BITS-1:0]; reads return 0.
  - 1 STATUS: RO, except write-1-to-clear on bit3.
    - bit0 full; bit1 empty; bit2 busy; bit3 overflow (sticky).
    - bits[15:8] FIFO count.
  - 2 DIVISOR: RW, DIV_WIDTH bits, zero-extended on read.
  - 3 CTRL: RW.
    - bit0 tx_en (reset 1); bit1 irq_en (reset 0).
    - bit2 fifo_clr: self-clearing; reads 0.
- Reads are combinational from bus_address, so the single-cycle core sees data in the same cycle. Writes commit at posedge clk when write_enable=1.
- mask_byte must include byte 0 for TXDATA/CTRL writes to take effect. DIVISOR writes honour mask_byte per byte.
- Reset values:
  - tx_o=1, irq_o=0.
  - FIFO empty, overflow=0.
  - DIVISOR=RESET_DIVISOR; CTRL=3'b001.
  - FSM IDLE.
- Push rules:
  - A push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
- fifo_clr empties the FIFO in the same edge and wins over a simultaneous push. It does not abort the frame in flight.
- Baud tick: the counter counts 0..eff_div-1, where eff_div = max(DIVISOR,1). One tick = one bit time.
- FSM states:
  - IDLE: tx_o=1. If tx_en && !empty, pop the FIFO head into the shift register, latch eff_div for the frame, and go to START.
  - START: tx_o=0 for one bit time, then DATA.
  - DATA: shift out LSB first, DATA_BITS bit times, then STOP.
  - STOP: tx_o=1 for STOP_BITS bit times, then IDLE. A back-to-back frame starts the cycle after STOP ends.
- Latency: a TXDATA write into an empty FIFO with FSM idle pops on the next edge. tx_o falls 1 cycle after the write edge.
- DIVISOR changes mid-frame take effect at the next frame start.
- Clearing tx_en mid-frame completes the current frame, then holds in IDLE.
- busy=1 in any state other than IDLE.
- irq_o = irq_en && empty && !busy, registered (1-cycle lag).
- Async reset mid-frame: tx_o goes high immediately, and the FIFO and all registers return to reset values.

Decomposition:
- uart_pkg holds:
  - register offsets (REG_TXDATA..REG_CTRL);
  - STATUS/CTRL bit positions;
  - the tx_state_t enum {IDLE, START, DATA, STOP}.
- Sub-module sync_fifo #(WIDTH, DEPTH):
  - push/pop/clr ports, data_out, full/empty/count outputs;
  - async active-low reset;
  - reused later for an RX path.
- The top module holds the register file, baud counter and FSM.

Test Plan:
- Reset then idle 100 cycles -> tx_o=1, irq_o=0, STATUS reads 0x00000002, DIVISOR reads 434.
- DIVISOR=4, write 0xA5 -> tx_o sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles; the start edge is 1 cycle after the write; busy=0 after the stop bit.
- DIVISOR=2, tx_en=0, write 17 bytes -> count=16, full=1, overflow=1. Write 0x8 to STATUS -> overflow=0. Set tx_en -> all 16 bytes are sent back-to-back with no idle gap between frames.
- DIVISOR=3, queue 2 bytes, then write 0 to DIVISOR during frame 1 -> frame 1 keeps 3-cycle bits; frame 2 uses 1-cycle bits.
- irq_en=1, send 1 byte -> irq_o=0 while busy; irq_o=1 one cycle after STOP completes. A push to a full FIFO in the same cycle as a pop is accepted (count stays full).
- Assert rst_n low mid-DATA with 3 bytes queued -> tx_o=1 immediately, STATUS=0x2 after release, and no further frames are sent.
